router_pkt_tx: RTL and testbench

Packet source for the write side of the 1x3 router. Accepts a packet request (destination address, payload length) and the payload bytes, and buffers the whole payload. It then drives header, payload and parity onto data_in/pkt_valid, stalling on busy. Afterwards it watches the router's error line and reports a per-packet status. It is synthesizable and sits in front of the router in both block-level benches and the integration top.

---
 rtl/router_pkt_tx_if.sv | 39 +++
 rtl/router_pkt_tx.sv | 198 +++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
// rtl/router_pkt_tx_if.sv - request, payload, router and status signals of the router packet source
//
// Purpose: bundles every handshake/bus signal of router_pkt_tx so the block
// and its environment connect through one port.
// Modports:
//   master - the packet source itself: takes requests, payload, busy and
//            error; drives req_ready, pl_ready, data_in, pkt_valid, sts_*.
//   slave  - the environment (request/payload producer, router, status sink).
// Signals:
//   req_valid/req_ready/req_addr[1:0]/req_len[5:0]  packet request
//   pl_data[7:0]/pl_valid/pl_ready                  payload bytes
//   data_in[7:0]/pkt_valid/busy/error               router write side
//   sts_valid/sts_code[1:0]                         per-request status

interface router_pkt_tx_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic       busy;
  logic       error;
  logic       sts_valid;
  logic [1:0] sts_code;

  modport master (
    input  req_valid, req_addr, req_len, pl_data, pl_valid, busy, error,
    output req_ready, pl_ready, data_in, pkt_valid, sts_valid, sts_code
  );

  modport slave (
    output req_valid, req_addr, req_len, pl_data, pl_valid, busy, error,
    input  req_ready, pl_ready, data_in, pkt_valid, sts_valid, sts_code
  );
endinterface

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - packet source for the write side of the 1x3 router
//
// Purpose: accepts a request (addr, len), buffers the whole payload, then
// drives header, payload and parity to the router without ever dropping
// pkt_valid inside a packet, honouring busy. Afterwards it watches the
// router error line for ERR_WAIT cycles and emits one status pulse.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - asynchronous active-low reset
//   bus  - router_pkt_tx_if.master (request, payload, router, status)
// Status codes: 00 ok, 01 router reported error, 10 request rejected.

module router_pkt_tx #(
  parameter int MAX_LEN  = 63,
  parameter int ERR_WAIT = 3,
  parameter int IPG      = 2
) (
  input logic            clk,
  input logic            rst,
  router_pkt_tx_if.master bus
);

  // CHK and GAP never overlap, so one down-counter width covers both.
  localparam int WAIT_MAX = (ERR_WAIT > IPG) ? ERR_WAIT : IPG;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD, HDR, PLD, PAR, CHK, RPT, GAP} state_t;

  state_t              state, state_n;
  logic [1:0]          addr_q, addr_n;
  logic [5:0]          len_q, len_n;
  logic [5:0]          wr_cnt, wr_n;
  logic [5:0]          rd_cnt, rd_n;
  logic [7:0]          parity, par_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_n;
  logic                err_seen, err_n;
  logic [1:0]          code_q, code_n;

  logic                req_ready_q, pl_ready_q, pkt_valid_q, sts_valid_q;
  logic [7:0]          data_q;
  logic [1:0]          sts_code_q;
  logic                req_ready_d, pl_ready_d, pkt_valid_d, sts_valid_d;
  logic [7:0]          data_d;
  logic [1:0]          sts_code_d;

  logic [7:0]          buf_mem [MAX_LEN];

  logic req_fire, pl_fire;
  assign req_fire = bus.req_valid & req_ready_q & (state == IDLE);
  assign pl_fire  = bus.pl_valid & pl_ready_q & (state == LOAD);

  // Payload buffer: no reset, contents are only read after a full LOAD.
  always_ff @(posedge clk) begin
    if (pl_fire) buf_mem[wr_cnt] <= bus.pl_data;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      parity      <= '0;
      wait_cnt    <= '0;
      err_seen    <= 1'b0;
      code_q      <= '0;
      req_ready_q <= 1'b0;
      pl_ready_q  <= 1'b0;
      pkt_valid_q <= 1'b0;
      data_q      <= '0;
      sts_valid_q <= 1'b0;
      sts_code_q  <= '0;
    end else begin
      state       <= state_n;
      addr_q      <= addr_n;
      len_q       <= len_n;
      wr_cnt      <= wr_n;
      rd_cnt      <= rd_n;
      parity      <= par_n;
      wait_cnt    <= wait_n;
      err_seen    <= err_n;
      code_q      <= code_n;
      req_ready_q <= req_ready_d;
      pl_ready_q  <= pl_ready_d;
      pkt_valid_q <= pkt_valid_d;
      data_q      <= data_d;
      sts_valid_q <= sts_valid_d;
      sts_code_q  <= sts_code_d;
    end
  end

  // Next state and datapath.
  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    len_n   = len_q;
    wr_n    = wr_cnt;
    rd_n    = rd_cnt;
    par_n   = parity;
    wait_n  = wait_cnt;
    err_n   = err_seen;
    code_n  = code_q;
    case (state)
      IDLE: begin
        if (req_fire) begin
          addr_n = bus.req_addr;
          len_n  = bus.req_len;
          wr_n   = '0;
          rd_n   = '0;
          err_n  = 1'b0;
          code_n = 2'b00;
          // Lengths beyond the buffer are rejected too so a smaller
          // MAX_LEN can never overrun buf_mem.
          if (bus.req_addr == 2'd3 || bus.req_len == 6'd0 ||
              int'(bus.req_len) > MAX_LEN) begin
            code_n  = 2'b10;
            state_n = RPT;
          end else begin
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        if (pl_fire) begin
          // Counter stops at len-1 instead of wrapping on the last byte.
          if (wr_cnt == len_q - 6'd1) begin
            state_n = HDR;
            par_n   = {len_q, addr_q};
          end else begin
            wr_n = wr_cnt + 6'd1;
          end
        end
      end
      HDR: begin
        if (!bus.busy) state_n = PLD;
      end
      PLD: begin
        if (!bus.busy) begin
          par_n = parity ^ buf_mem[rd_cnt];
          if (rd_cnt == len_q - 6'd1) state_n = PAR;
          else                        rd_n = rd_cnt + 6'd1;
        end
      end
      PAR: begin
        if (!bus.busy) begin
          state_n = CHK;
          wait_n  = '0;
        end
      end
      CHK: begin
        err_n = err_seen | bus.error;
        if (wait_cnt == WAIT_W'(ERR_WAIT - 1)) begin
          code_n  = (err_seen | bus.error) ? 2'b01 : 2'b00;
          state_n = RPT;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      RPT: begin
        state_n = GAP;
        wait_n  = '0;
      end
      GAP: begin
        if (wait_cnt == WAIT_W'(IPG - 1)) state_n = IDLE;
        else                              wait_n = wait_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come out of flops
  // aligned with the state they belong to. A stalled byte re-decodes to
  // the same value because state and counters do not move under busy.
  always_comb begin
    req_ready_d = (state_n == IDLE);
    pl_ready_d  = (state_n == LOAD);
    pkt_valid_d = (state_n == HDR) || (state_n == PLD);
    sts_valid_d = (state_n == RPT);
    sts_code_d  = (state_n == RPT) ? code_n : 2'b00;
    data_d      = 8'h00;
    case (state_n)
      HDR:     data_d = {len_n, addr_n};
      PLD:     data_d = buf_mem[rd_n];
      PAR:     data_d = par_n;
      default: data_d = 8'h00;
    endcase
  end

  assign bus.req_ready = req_ready_q;
  assign bus.pl_ready  = pl_ready_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.data_in   = data_q;
  assign bus.sts_valid = sts_valid_q;
  assign bus.sts_code  = sts_code_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - self-checking bench for router_pkt_tx

module tb_router_pkt_tx;

  localparam int IPG = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  router_pkt_tx_if bus();

  router_pkt_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int addr;
    int len;
    int pat;
    int busy_idx;
    int busy_len;
    int err_delay;
    int exp_code;
    int exp_n;
    int exp_hdr;
    int exp_par;
    int exp_hold;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [7:0] pat_byte(input int pat, input int i);
    return (pat == 0) ? 8'((i + 1) * 17) : 8'(i);
  endfunction

  logic [7:0] cap_d  [80];
  logic       cap_pv [80];
  int r_code, r_sts_n, r_nbytes, r_pl_ever, r_pv_ever;
  int r_hold, r_hold_bad, r_gap, r_timeout;

  task automatic run_pkt(input vec_t v);
    int cyc, wr_idx, nb, held, acc_cyc;
    bit in_pkt, par_done, sts_seen, done;
    logic [7:0] first_d;
    for (int i = 0; i < 80; i++) begin
      cap_d[i]  = 8'h00;
      cap_pv[i] = 1'b0;
    end
    r_code = -1; r_sts_n = 0; r_nbytes = 0; r_pl_ever = 0; r_pv_ever = 0;
    r_hold = 0; r_hold_bad = 0; r_gap = 0; r_timeout = 0;
    wr_idx = 0; nb = 0; held = 0; acc_cyc = 0; first_d = 8'h00;
    in_pkt = 0; par_done = 0; sts_seen = 0; done = 0;
    cyc = 0;
    while (bus.req_ready !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) r_timeout = 1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 2'(v.addr);
    bus.req_len   = 6'(v.len);
    @(negedge clk);
    bus.req_valid = 1'b0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      if (bus.pl_ready === 1'b1) begin
        r_pl_ever = 1;
        if (wr_idx < v.len) begin
          bus.pl_valid = 1'b1;
          bus.pl_data  = pat_byte(v.pat, wr_idx);
          wr_idx++;
        end else begin
          bus.pl_valid = 1'b0;
        end
      end else begin
        bus.pl_valid = 1'b0;
      end
      if (bus.pkt_valid === 1'b1) begin
        in_pkt    = 1;
        r_pv_ever = 1;
      end
      if (bus.pkt_valid === 1'b1 || (in_pkt && !par_done)) begin
        if (nb == v.busy_idx) begin
          if (r_hold == 0) first_d = bus.data_in;
          else if (bus.data_in !== first_d) r_hold_bad++;
          r_hold++;
        end
        if (nb == v.busy_idx && held < v.busy_len) begin
          bus.busy = 1'b1;
          held++;
        end else begin
          bus.busy = 1'b0;
          if (nb < 80) begin
            cap_d[nb]  = bus.data_in;
            cap_pv[nb] = bus.pkt_valid;
          end
          if (bus.pkt_valid !== 1'b1) begin
            par_done = 1;
            acc_cyc  = cyc;
          end
          nb++;
        end
      end else begin
        bus.busy = 1'b0;
      end
      bus.error = par_done && (v.err_delay > 0) && (cyc == acc_cyc + v.err_delay);
      if (bus.sts_valid === 1'b1) begin
        r_sts_n++;
        r_code   = int'(bus.sts_code);
        sts_seen = 1;
      end else if (sts_seen) begin
        if (bus.req_ready === 1'b1) done = 1;
        else r_gap++;
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) r_timeout = 1;
    r_nbytes = nb;
    bus.pl_valid = 1'b0;
    bus.busy     = 1'b0;
    bus.error    = 1'b0;
  endtask

  task automatic check_vec(input int k, input vec_t v);
    int bad;
    check($sformatf("v%0d timeout", k), r_timeout, 0);
    check($sformatf("v%0d sts_pulses", k), r_sts_n, 1);
    check($sformatf("v%0d sts_code", k), r_code, v.exp_code);
    check($sformatf("v%0d byte_count", k), r_nbytes, v.exp_n);
    check($sformatf("v%0d pl_ready_seen", k), r_pl_ever, (v.exp_n != 0) ? 1 : 0);
    check($sformatf("v%0d pkt_valid_seen", k), r_pv_ever, (v.exp_n != 0) ? 1 : 0);
    check($sformatf("v%0d gap_cycles", k), r_gap, IPG);
    if (v.exp_n != 0) begin
      check($sformatf("v%0d header", k), cap_d[0], v.exp_hdr);
      check($sformatf("v%0d parity", k), cap_d[v.exp_n - 1], v.exp_par);
      check($sformatf("v%0d parity_pv", k), cap_pv[v.exp_n - 1], 0);
      bad = (cap_pv[0] !== 1'b1) ? 1 : 0;
      for (int i = 1; i <= v.len; i++)
        if (cap_d[i] !== pat_byte(v.pat, i - 1) || cap_pv[i] !== 1'b1) bad++;
      check($sformatf("v%0d payload_errors", k), bad, 0);
      check($sformatf("v%0d hold_cycles", k), r_hold, v.exp_hold);
      check($sformatf("v%0d hold_changed", k), r_hold_bad, 0);
    end
  endtask

  initial begin
    int nb, cyc, sts_cnt;
    bus.req_valid = 1'b0;
    bus.req_addr  = 2'd0;
    bus.req_len   = 6'd0;
    bus.pl_data   = 8'h00;
    bus.pl_valid  = 1'b0;
    bus.busy      = 1'b0;
    bus.error     = 1'b0;

    //             addr len pat bidx blen err code  n   hdr    par   hold
    vecs[0] = '{1,  3, 0, -1, 0, 0, 0,  5, 'h0D, 'h0D, 0};
    vecs[1] = '{1,  3, 0,  2, 4, 0, 0,  5, 'h0D, 'h0D, 5};
    vecs[2] = '{3,  5, 0, -1, 0, 0, 2,  0, 0,    0,    0};
    vecs[3] = '{0,  0, 0, -1, 0, 0, 2,  0, 0,    0,    0};
    vecs[4] = '{2, 63, 1, -1, 0, 0, 0, 65, 'hFE, 'hC1, 0};
    vecs[5] = '{1,  3, 0, -1, 0, 2, 1,  5, 'h0D, 'h0D, 0};
    vecs[6] = '{1,  3, 0, -1, 0, 5, 0,  5, 'h0D, 'h0D, 0};
    vecs[7] = '{0,  1, 0,  0, 3, 0, 0,  3, 'h04, 'h15, 4};
    vecs[8] = '{2,  2, 0,  3, 2, 1, 1,  4, 'h0A, 'h39, 3};

    // Reset values
    #1 rst = 1'b0;
    #2;
    check("rst req_ready", bus.req_ready, 0);
    check("rst pl_ready", bus.pl_ready, 0);
    check("rst data_in", bus.data_in, 0);
    check("rst pkt_valid", bus.pkt_valid, 0);
    check("rst sts_valid", bus.sts_valid, 0);
    check("rst sts_code", bus.sts_code, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst req_ready", bus.req_ready, 1);

    for (int k = 0; k < 9; k++) begin
      run_pkt(vecs[k]);
      check_vec(k, vecs[k]);
    end

    // Reset in the middle of the payload of a len=10 packet
    cyc = 0;
    while (bus.req_ready !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = 2'd1;
    bus.req_len   = 6'd10;
    @(negedge clk);
    bus.req_valid = 1'b0;
    nb = 0; cyc = 0; sts_cnt = 0;
    while (nb < 4 && cyc < 200) begin
      if (bus.pl_ready === 1'b1) begin
        bus.pl_valid = 1'b1;
        bus.pl_data  = 8'(8'hA0 + cyc);
      end else begin
        bus.pl_valid = 1'b0;
      end
      if (bus.pkt_valid === 1'b1) nb++;
      if (bus.sts_valid === 1'b1) sts_cnt++;
      if (nb < 4) begin
        @(negedge clk);
        cyc++;
      end
    end
    bus.pl_valid = 1'b0;
    check("midrst reached_pld", (nb == 4) ? 1 : 0, 1);
    check("midrst pkt_valid_before", bus.pkt_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("midrst pkt_valid_async", bus.pkt_valid, 0);
    check("midrst data_in_async", bus.data_in, 0);
    check("midrst req_ready_async", bus.req_ready, 0);
    @(negedge clk);
    if (bus.sts_valid === 1'b1) sts_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst req_ready_after", bus.req_ready, 1);
    for (int i = 0; i < 10; i++) begin
      if (bus.sts_valid === 1'b1 || bus.pkt_valid === 1'b1) sts_cnt++;
      @(negedge clk);
    end
    check("midrst stray_activity", sts_cnt, 0);

    // A normal packet still goes through after the aborted one
    run_pkt(vecs[0]);
    check_vec(9, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
